// File: rtl/dbf_ch_zone_apod_pkg.sv
// Shared defaults and state encoding for the DBF zone-focused apodised receive channel.
package dbf_ch_zone_apod_pkg;

  localparam int DEF_INPUT_WD = 14;
  localparam int DEF_APO_WD   = 16;
  localparam int DEF_OUT_WD   = 32;
  localparam int DEF_DLY_WD   = 8;
  localparam int DEF_ZONE_AW  = 6;
  localparam int DEF_ZONE_LEN = 64;
  localparam int DEF_SHIFT    = 15;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dbf_ch_zone_apod_delay_line.sv
// Circular sample RAM with offset read, zero-delay bypass and fill-count gating.
module dbf_delay_line #(
  parameter int DW = 14,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          we_i,
  input  logic [DW-1:0] din_i,
  input  logic [AW-1:0] dly_i,
  output logic [DW-1:0] dout_o
);

  localparam logic [AW:0] FILL_FULL = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW-1:0] rd_addr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (we_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[wr_ptr_q] <= din_i;
    end
  end

  assign rd_addr = wr_ptr_q - dly_i;

  // fill_q counts samples already stored, so a delay beyond it points at stale RAM
  always_comb begin
    if (dly_i == '0) begin
      dout_o = din_i;
    end else if (fill_q < {1'b0, dly_i}) begin
      dout_o = '0;
    end else begin
      dout_o = mem[rd_addr];
    end
  end

endmodule

// File: rtl/dbf_ch_zone_apod.sv
// DBF receive channel: per-zone coarse delay, apodisation multiply, round and saturate.
module dbf_ch_zone_apod
  import dbf_ch_zone_apod_pkg::*;
#(
  parameter int INPUT_WD = DEF_INPUT_WD,
  parameter int APO_WD   = DEF_APO_WD,
  parameter int OUT_WD   = DEF_OUT_WD,
  parameter int DLY_WD   = DEF_DLY_WD,
  parameter int ZONE_AW  = DEF_ZONE_AW,
  parameter int ZONE_LEN = DEF_ZONE_LEN,
  parameter int SHIFT    = DEF_SHIFT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       tx_en,
  input  logic signed [INPUT_WD-1:0] ch_in,
  input  logic signed [APO_WD-1:0]   apo_din,
  input  logic [ZONE_AW-1:0]         lut_addr,
  input  logic [DLY_WD-1:0]          lut_wdata,
  input  logic                       lut_we,
  output logic signed [INPUT_WD-1:0] cd_dout,
  output logic                       cd_dout_valid,
  output logic signed [OUT_WD-1:0]   dbf_dout,
  output logic                       dbf_dout_valid,
  output logic                       sat_flag
);

  localparam int PW     = INPUT_WD + APO_WD;
  localparam int EW     = (PW + 1 > OUT_WD) ? PW + 1 : OUT_WD;
  localparam int ZC_W   = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [ZC_W-1:0]    ZONE_LAST = ZC_W'(ZONE_LEN - 1);
  localparam logic [ZONE_AW-1:0] ZIDX_MAX  = {ZONE_AW{1'b1}};
  localparam logic signed [EW-1:0] RND =
    (SHIFT > 0) ? (EW'(1) << RND_SH) : '0;
  localparam logic signed [EW-1:0] SAT_MAX =
    {{(EW - OUT_WD + 1){1'b0}}, {(OUT_WD - 1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN =
    {{(EW - OUT_WD + 1){1'b1}}, {(OUT_WD - 1){1'b0}}};

  state_e state_q, state_d;
  logic   run_en, run_entry, lut_wr, sv;

  logic [DLY_WD-1:0]  lut_mem [2**ZONE_AW];
  logic [DLY_WD-1:0]  dly;
  logic [ZC_W-1:0]    zone_cnt_q, zone_cnt_d;
  logic [ZONE_AW-1:0] zone_idx_q, zone_idx_d;

  logic [INPUT_WD-1:0]        cd_rd;
  logic signed [INPUT_WD-1:0] cd_q;
  logic signed [APO_WD-1:0]   apo_q;
  logic signed [PW-1:0]       prod_q;
  logic signed [OUT_WD-1:0]   out_q, out_d;
  logic                       cd_v_q, prod_v_q, out_v_q, sat_q;
  logic signed [EW-1:0]       prod_ext, rounded, shifted;
  logic                       clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dropping start flushes the pipeline on the very next edge, so it gates sv too
  always_comb begin
    run_en    = (state_q == RUN) && start;
    run_entry = (state_q == IDLE) && start;
    lut_wr    = (state_q == IDLE) && lut_we;
    sv        = run_en && !tx_en;
  end

  always_ff @(posedge clk) begin
    if (lut_wr) begin
      lut_mem[lut_addr] <= lut_wdata;
    end
  end

  assign dly = lut_mem[zone_idx_q];

  always_comb begin
    zone_cnt_d = zone_cnt_q;
    zone_idx_d = zone_idx_q;
    if (run_entry) begin
      zone_cnt_d = '0;
      zone_idx_d = '0;
    end else if (sv) begin
      if (zone_cnt_q == ZONE_LAST) begin
        zone_cnt_d = '0;
        if (zone_idx_q != ZIDX_MAX) begin
          zone_idx_d = zone_idx_q + 1'b1;
        end
      end else begin
        zone_cnt_d = zone_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zone_cnt_q <= '0;
      zone_idx_q <= '0;
    end else begin
      zone_cnt_q <= zone_cnt_d;
      zone_idx_q <= zone_idx_d;
    end
  end

  dbf_delay_line #(
    .DW (INPUT_WD),
    .AW (DLY_WD)
  ) u_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (run_entry),
    .we_i    (sv),
    .din_i   (ch_in),
    .dly_i   (dly),
    .dout_o  (cd_rd)
  );

  // Round half up, then clamp in a width wide enough that neither step can wrap
  always_comb begin
    prod_ext = EW'(prod_q);
    rounded  = prod_ext + RND;
    shifted  = rounded >>> SHIFT;
    clamp    = 1'b0;
    out_d    = shifted[OUT_WD-1:0];
    if (shifted > SAT_MAX) begin
      out_d = SAT_MAX[OUT_WD-1:0];
      clamp = 1'b1;
    end else if (shifted < SAT_MIN) begin
      out_d = SAT_MIN[OUT_WD-1:0];
      clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_v_q   <= 1'b0;
      prod_v_q <= 1'b0;
      out_v_q  <= 1'b0;
      cd_q     <= '0;
      apo_q    <= '0;
      prod_q   <= '0;
      out_q    <= '0;
    end else if (!run_en) begin
      cd_v_q   <= 1'b0;
      prod_v_q <= 1'b0;
      out_v_q  <= 1'b0;
    end else begin
      cd_v_q   <= sv;
      prod_v_q <= cd_v_q;
      out_v_q  <= prod_v_q;
      if (sv) begin
        cd_q  <= $signed(cd_rd);
        apo_q <= apo_din;
      end
      if (cd_v_q) begin
        prod_q <= PW'(cd_q) * PW'(apo_q);
      end
      if (prod_v_q) begin
        out_q <= out_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (run_entry) begin
      sat_q <= 1'b0;
    end else if (run_en && prod_v_q && clamp) begin
      sat_q <= 1'b1;
    end
  end

  assign cd_dout        = cd_v_q ? cd_q : '0;
  assign cd_dout_valid  = cd_v_q;
  assign dbf_dout       = out_v_q ? out_q : '0;
  assign dbf_dout_valid = out_v_q;
  assign sat_flag       = sat_q;

endmodule

// File: tb/tb_dbf_ch_zone_apod.sv
// Directed bench: default-width channel plus a narrow 16-bit, 4-zone variant on shared inputs.
module tb_dbf_ch_zone_apod;

  logic clk = 1'b0;
  logic rst_n, start, txEn, lutWe;
  logic signed [13:0] chIn;
  logic signed [15:0] apoDin;
  logic [5:0] lutAddr;
  logic [7:0] lutWdata;

  logic signed [13:0] cdA, cdB;
  logic               cdValidA, cdValidB;
  logic signed [31:0] dbfA;
  logic signed [15:0] dbfB;
  logic               dbfValidA, dbfValidB, satA, satB;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  dbf_ch_zone_apod dutA (
    .clk (clk), .rst_n (rst_n), .start (start), .tx_en (txEn),
    .ch_in (chIn), .apo_din (apoDin), .lut_addr (lutAddr),
    .lut_wdata (lutWdata), .lut_we (lutWe),
    .cd_dout (cdA), .cd_dout_valid (cdValidA), .dbf_dout (dbfA),
    .dbf_dout_valid (dbfValidA), .sat_flag (satA)
  );

  dbf_ch_zone_apod #(
    .OUT_WD (16), .SHIFT (0), .ZONE_LEN (4), .ZONE_AW (2)
  ) dutB (
    .clk (clk), .rst_n (rst_n), .start (start), .tx_en (txEn),
    .ch_in (chIn), .apo_din (apoDin), .lut_addr (lutAddr[1:0]),
    .lut_wdata (lutWdata), .lut_we (lutWe),
    .cd_dout (cdB), .cd_dout_valid (cdValidB), .dbf_dout (dbfB),
    .dbf_dout_valid (dbfValidB), .sat_flag (satB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeLut(input logic [5:0] a, input logic [7:0] d);
    lutAddr  = a;
    lutWdata = d;
    lutWe    = 1'b1;
    tick();
    lutWe    = 1'b0;
  endtask

  task automatic goIdle();
    start = 1'b0;
    txEn  = 1'b0;
    lutWe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic beginRun();
    start = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; txEn = 1'b0; lutWe = 1'b0;
    chIn = '0; apoDin = '0; lutAddr = '0; lutWdata = '0;
    repeat (2) tick();
    testsRun++; if (cdA !== 14'sd0) begin testsFailed++; $display("[TB] FAIL reset_cd: got %0d want 0", cdA); end
    testsRun++; if (cdValidA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_cd_valid: got %b want 0", cdValidA); end
    testsRun++; if (dbfA !== 32'sd0) begin testsFailed++; $display("[TB] FAIL reset_dbf: got %0d want 0", dbfA); end
    testsRun++; if (dbfValidA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dbf_valid: got %b want 0", dbfValidA); end
    testsRun++; if (satA !== 1'b0 || satB !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sat: got %b/%b want 0/0", satA, satB); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    writeLut(6'd0, 8'd0);
    apoDin = 16'sh7FFF;
    beginRun();
    for (int k = 0; k < 12; k++) begin
      logic expV;
      txEn = (k >= 10);
      chIn = 14'(k + 1);
      tick();
      testsRun++;
      if (k < 10) begin
        if (cdValidA !== 1'b1 || cdA !== 14'(k + 1)) begin testsFailed++; $display("[TB] FAIL pass_cd k=%0d: got %b/%0d want 1/%0d", k, cdValidA, cdA, k + 1); end
      end else begin
        if (cdValidA !== 1'b0 || cdA !== 14'sd0) begin testsFailed++; $display("[TB] FAIL pass_cd_idle k=%0d: got %b/%0d want 0/0", k, cdValidA, cdA); end
      end
      expV = (k >= 2);
      testsRun++;
      if (dbfValidA !== expV) begin testsFailed++; $display("[TB] FAIL pass_dbf_valid k=%0d: got %b want %b", k, dbfValidA, expV); end
      if (expV) begin
        testsRun++;
        if (dbfA !== 32'(k - 1)) begin testsFailed++; $display("[TB] FAIL pass_dbf k=%0d: got %0d want %0d", k, dbfA, k - 1); end
      end
    end
    goIdle();
  endtask

  task automatic test_coarse_delay();
    writeLut(6'd0, 8'd5);
    apoDin = 16'sh4000;
    chIn = 14'sd100;
    beginRun();
    for (int k = 0; k < 12; k++) begin
      int j;
      txEn = (k >= 10);
      tick();
      if (k < 10) begin
        testsRun++;
        if (cdValidA !== 1'b1 || cdA !== ((k < 5) ? 14'sd0 : 14'sd100)) begin testsFailed++; $display("[TB] FAIL delay_cd k=%0d: got %b/%0d", k, cdValidA, cdA); end
      end
      j = k - 2;
      if (j >= 0) begin
        testsRun++;
        if (dbfValidA !== 1'b1 || dbfA !== ((j < 5) ? 32'sd0 : 32'sd50)) begin testsFailed++; $display("[TB] FAIL delay_dbf j=%0d: got %b/%0d want 1/%0d", j, dbfValidA, dbfA, (j < 5) ? 0 : 50); end
      end
    end
    goIdle();
  endtask

  task automatic test_zones();
    int dz [4] = '{0, 3, 1, 2};
    for (int z = 0; z < 4; z++) writeLut(6'(z), 8'(dz[z]));
    apoDin = 16'sd1;
    beginRun();
    for (int k = 0; k < 26; k++) begin
      int j, want;
      txEn = (k >= 24);
      chIn = 14'(k + 1);
      tick();
      j = k - 2;
      if (j >= 0 && j < 24) begin
        want = j + 1 - dz[(j / 4 > 3) ? 3 : j / 4];
        testsRun++;
        if (dbfValidB !== 1'b1 || dbfB !== 16'(want)) begin testsFailed++; $display("[TB] FAIL zone_dbf j=%0d: got %b/%0d want 1/%0d", j, dbfValidB, dbfB, want); end
      end
    end
    testsRun++;
    if (satB !== 1'b0) begin testsFailed++; $display("[TB] FAIL zone_sat: got %b want 0", satB); end
    goIdle();
  endtask

  task automatic test_back_to_back();
    logic svHist [32];
    int s = 0;
    int outIdx = 0;
    writeLut(6'd0, 8'd2);
    apoDin = 16'sh4000;
    beginRun();
    for (int c = 0; c < 22; c++) begin
      logic bubble, expV;
      int wantCd;
      bubble = ((c % 5) >= 3) || (c >= 19);
      txEn = bubble;
      chIn = bubble ? 14'sd999 : 14'(2 * (s + 1));
      svHist[c] = !bubble;
      tick();
      testsRun++;
      if (cdValidA !== svHist[c]) begin testsFailed++; $display("[TB] FAIL bub_cd_valid c=%0d: got %b want %b", c, cdValidA, svHist[c]); end
      wantCd = bubble ? 0 : ((s < 2) ? 0 : 2 * (s - 1));
      testsRun++;
      if (cdA !== 14'(wantCd)) begin testsFailed++; $display("[TB] FAIL bub_cd c=%0d: got %0d want %0d", c, cdA, wantCd); end
      if (!bubble) s++;
      expV = (c >= 2) ? svHist[c - 2] : 1'b0;
      testsRun++;
      if (dbfValidA !== expV) begin testsFailed++; $display("[TB] FAIL bub_dbf_valid c=%0d: got %b want %b", c, dbfValidA, expV); end
      testsRun++;
      if (expV) begin
        if (dbfA !== ((outIdx < 2) ? 32'sd0 : 32'(outIdx - 1))) begin testsFailed++; $display("[TB] FAIL bub_dbf n=%0d: got %0d want %0d", outIdx, dbfA, (outIdx < 2) ? 0 : outIdx - 1); end
        outIdx++;
      end else if (dbfA !== 32'sd0) begin
        testsFailed++; $display("[TB] FAIL bub_dbf_idle c=%0d: got %0d want 0", c, dbfA);
      end
    end
    testsRun++;
    if (outIdx != 12) begin testsFailed++; $display("[TB] FAIL bub_count: got %0d want 12", outIdx); end
    goIdle();
  endtask

  task automatic test_saturation();
    writeLut(6'd0, 8'd0);
    apoDin = 16'sd32767;
    beginRun();
    testsRun++;
    if (satB !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_start: got %b want 0", satB); end
    for (int k = 0; k < 4; k++) begin
      txEn = (k >= 2);
      chIn = (k == 0) ? 14'sd8191 : -14'sd8192;
      tick();
      if (k == 2) begin
        testsRun++;
        if (dbfValidB !== 1'b1 || dbfB !== 16'sd32767) begin testsFailed++; $display("[TB] FAIL sat_pos: got %b/%0d want 1/32767", dbfValidB, dbfB); end
        testsRun++;
        if (satB !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_flag: got %b want 1", satB); end
        testsRun++;
        if (dbfA !== 32'sd8191 || satA !== 1'b0) begin testsFailed++; $display("[TB] FAIL nosat_pos: got %0d/%b want 8191/0", dbfA, satA); end
      end
      if (k == 3) begin
        testsRun++;
        if (dbfValidB !== 1'b1 || dbfB !== -16'sd32768) begin testsFailed++; $display("[TB] FAIL sat_neg: got %b/%0d want 1/-32768", dbfValidB, dbfB); end
        testsRun++;
        if (dbfA !== -32'sd8192) begin testsFailed++; $display("[TB] FAIL nosat_neg: got %0d want -8192", dbfA); end
      end
    end
    goIdle();
    testsRun++;
    if (satB !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_sticky: got %b want 1", satB); end
    beginRun();
    testsRun++;
    if (satB !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_clear: got %b want 0", satB); end
    goIdle();
  endtask

  task automatic test_restart();
    writeLut(6'd0, 8'd3);
    apoDin = 16'sh7FFF;
    beginRun();
    for (int k = 0; k < 258; k++) begin
      chIn = 14'(k + 1);
      tick();
    end
    lutAddr = 6'd0; lutWdata = 8'd7; lutWe = 1'b1; chIn = 14'sd7;
    tick();
    lutWe = 1'b0;
    testsRun++;
    if (dbfValidA !== 1'b1) begin testsFailed++; $display("[TB] FAIL stop_pre_valid: got %b want 1", dbfValidA); end
    start = 1'b0;
    tick();
    testsRun++;
    if (cdValidA !== 1'b0 || dbfValidA !== 1'b0 || dbfA !== 32'sd0 || cdA !== 14'sd0) begin testsFailed++; $display("[TB] FAIL stop_flush: got %b/%b/%0d/%0d want 0/0/0/0", cdValidA, dbfValidA, dbfA, cdA); end
    tick();
    testsRun++;
    if (dbfValidA !== 1'b0) begin testsFailed++; $display("[TB] FAIL stop_partial: got %b want 0", dbfValidA); end
    tick();
    beginRun();
    for (int k = 0; k < 5; k++) begin
      chIn = 14'(50 + k);
      tick();
      testsRun++;
      if (cdValidA !== 1'b1 || cdA !== ((k < 3) ? 14'sd0 : 14'(47 + k))) begin testsFailed++; $display("[TB] FAIL restart_cd k=%0d: got %b/%0d want 1/%0d", k, cdValidA, cdA, (k < 3) ? 0 : 47 + k); end
    end
    goIdle();
  endtask

  task automatic test_reset_midrun();
    writeLut(6'd0, 8'd0);
    apoDin = 16'sh7FFF;
    beginRun();
    for (int k = 0; k < 5; k++) begin
      chIn = 14'(k + 1);
      tick();
    end
    testsRun++;
    if (dbfValidA !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_pre: got %b want 1", dbfValidA); end
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if (cdValidA !== 1'b0 || dbfValidA !== 1'b0 || dbfA !== 32'sd0 || cdA !== 14'sd0) begin testsFailed++; $display("[TB] FAIL midrst_outputs: got %b/%b/%0d/%0d want 0/0/0/0", cdValidA, dbfValidA, dbfA, cdA); end
    start = 1'b0;
    rst_n = 1'b1;
    goIdle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_coarse_delay();
    test_zones();
    test_back_to_back();
    test_saturation();
    test_restart();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
